// File: rtl/timekeeper_if.sv
// timekeeper_if: control, set bus and time/strobe outputs of the timekeeper.
// The master side drives controls and the set bus; the slave side is the counter.
interface timekeeper_if #(
  parameter int PRE_BITS = 7
);
  logic                run;
  logic                set_stb;
  logic                alarm_stb;
  logic                alarm_clr;
  logic [4:0]          set_hours;
  logic [5:0]          set_minutes;
  logic [5:0]          set_seconds;
  logic [PRE_BITS-1:0] sub;
  logic [5:0]          seconds;
  logic [5:0]          minutes;
  logic [4:0]          hours;
  logic                s_tick;
  logic                m_tick;
  logic                h_tick;
  logic                d_tick;
  logic                alarm_armed;
  logic                alarm_hit;
  logic                set_err;

  modport master (
    output run, set_stb, alarm_stb, alarm_clr, set_hours, set_minutes, set_seconds,
    input  sub, seconds, minutes, hours, s_tick, m_tick, h_tick, d_tick,
           alarm_armed, alarm_hit, set_err
  );

  modport slave (
    input  run, set_stb, alarm_stb, alarm_clr, set_hours, set_minutes, set_seconds,
    output sub, seconds, minutes, hours, s_tick, m_tick, h_tick, d_tick,
           alarm_armed, alarm_hit, set_err
  );
endinterface

// File: rtl/timekeeper.sv
// timekeeper: single-clock time-of-day counter. A prescaler produces a
// once-per-second enable; seconds/minutes/hours cascade on that enable in
// one edge. Supports run/pause, validated time load, a minute-resolution
// alarm and one-cycle rollover strobes. All outputs are registered.
module timekeeper #(
  parameter int TICKS_PER_SEC = 100,
  parameter int PRE_BITS      = 7,
  parameter int HOURS_PER_DAY = 24
) (
  input  logic          clk,
  input  logic          rst,
  timekeeper_if.slave   bus
);

  localparam logic [PRE_BITS-1:0] SUB_MAX  = PRE_BITS'(TICKS_PER_SEC - 1);
  localparam logic [4:0]          HOUR_MAX = 5'(HOURS_PER_DAY - 1);
  localparam logic [5:0]          HOUR_LIM = 6'(HOURS_PER_DAY);
  localparam logic [5:0]          SM_MAX   = 6'd59;
  localparam logic [5:0]          SM_LIM   = 6'd60;

  // Registered state and outputs
  logic [PRE_BITS-1:0] r_sub;
  logic [5:0]          r_seconds, r_minutes;
  logic [4:0]          r_hours;
  logic                r_s_tick, r_m_tick, r_h_tick, r_d_tick;
  logic                r_alarm_hit, r_set_err, r_armed;
  logic [4:0]          r_alm_hours;
  logic [5:0]          r_alm_minutes;

  // Next-state values
  logic [PRE_BITS-1:0] w_sub_n;
  logic [5:0]          w_seconds_n, w_minutes_n;
  logic [4:0]          w_hours_n;
  logic                w_s_tick, w_m_tick, w_h_tick, w_d_tick, w_hit;

  // Set-bus validation; alarm ignores the seconds field
  logic w_hm_ok, w_set_ok, w_alm_ok, w_load, w_alm_load, w_err;

  assign w_hm_ok    = ({1'b0, bus.set_hours} < HOUR_LIM) && (bus.set_minutes < SM_LIM);
  assign w_set_ok   = w_hm_ok && (bus.set_seconds < SM_LIM);
  assign w_alm_ok   = w_hm_ok;
  assign w_load     = bus.set_stb && w_set_ok;
  assign w_alm_load = bus.alarm_stb && w_alm_ok;
  assign w_err      = (bus.set_stb && !w_set_ok) || (bus.alarm_stb && !w_alm_ok);

  // Next time and strobes: a valid load beats counting and silences all strobes
  always_comb begin
    w_sub_n     = r_sub;
    w_seconds_n = r_seconds;
    w_minutes_n = r_minutes;
    w_hours_n   = r_hours;
    w_s_tick    = 1'b0;
    w_m_tick    = 1'b0;
    w_h_tick    = 1'b0;
    w_d_tick    = 1'b0;
    w_hit       = 1'b0;
    if (w_load) begin
      w_sub_n     = '0;
      w_seconds_n = bus.set_seconds;
      w_minutes_n = bus.set_minutes;
      w_hours_n   = bus.set_hours;
    end else if (bus.run) begin
      if (r_sub == SUB_MAX) begin
        w_sub_n  = '0;
        w_s_tick = 1'b1;
        if (r_seconds == SM_MAX) begin
          w_seconds_n = 6'd0;
          w_m_tick    = 1'b1;
          if (r_minutes == SM_MAX) begin
            w_minutes_n = 6'd0;
            w_h_tick    = 1'b1;
            if (r_hours == HOUR_MAX) begin
              w_hours_n = 5'd0;
              w_d_tick  = 1'b1;
            end else begin
              w_hours_n = r_hours + 5'd1;
            end
          end else begin
            w_minutes_n = r_minutes + 6'd1;
          end
        end else begin
          w_seconds_n = r_seconds + 6'd1;
        end
      end else begin
        w_sub_n = r_sub + PRE_BITS'(1);
      end
      // Alarm compares the new hh:mm with the alarm stored before this edge
      w_hit = w_m_tick && r_armed &&
              (w_hours_n == r_alm_hours) && (w_minutes_n == r_alm_minutes);
    end else begin
      w_sub_n = r_sub;
    end
  end

  // Time counters and strobe registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sub       <= '0;
      r_seconds   <= 6'd0;
      r_minutes   <= 6'd0;
      r_hours     <= 5'd0;
      r_s_tick    <= 1'b0;
      r_m_tick    <= 1'b0;
      r_h_tick    <= 1'b0;
      r_d_tick    <= 1'b0;
      r_alarm_hit <= 1'b0;
      r_set_err   <= 1'b0;
    end else begin
      r_sub       <= w_sub_n;
      r_seconds   <= w_seconds_n;
      r_minutes   <= w_minutes_n;
      r_hours     <= w_hours_n;
      r_s_tick    <= w_s_tick;
      r_m_tick    <= w_m_tick;
      r_h_tick    <= w_h_tick;
      r_d_tick    <= w_d_tick;
      r_alarm_hit <= w_hit;
      r_set_err   <= w_err;
    end
  end

  // Alarm time and arm flag; clear takes priority over a same-edge arm
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alm_hours   <= 5'd0;
      r_alm_minutes <= 6'd0;
      r_armed       <= 1'b0;
    end else begin
      if (w_alm_load) begin
        r_alm_hours   <= bus.set_hours;
        r_alm_minutes <= bus.set_minutes;
      end
      if (bus.alarm_clr) begin
        r_armed <= 1'b0;
      end else if (w_alm_load) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign bus.sub         = r_sub;
  assign bus.seconds     = r_seconds;
  assign bus.minutes     = r_minutes;
  assign bus.hours       = r_hours;
  assign bus.s_tick      = r_s_tick;
  assign bus.m_tick      = r_m_tick;
  assign bus.h_tick      = r_h_tick;
  assign bus.d_tick      = r_d_tick;
  assign bus.alarm_armed = r_armed;
  assign bus.alarm_hit   = r_alarm_hit;
  assign bus.set_err     = r_set_err;

endmodule

// File: tb/tb_timekeeper.sv
// tb_timekeeper: directed stimulus against a time-as-tick-count model.
// The model holds the time of day as one integer count of clock ticks since
// midnight; outputs and strobes are derived from it with division/modulo.
module tb_timekeeper;
  localparam int TPS  = 4;
  localparam int PB   = 3;
  localparam int HPD  = 24;
  localparam int DAYT = HPD * 3600 * TPS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  timekeeper_if #(.PRE_BITS(PB)) bus ();

  timekeeper #(.TICKS_PER_SEC(TPS), .PRE_BITS(PB), .HOURS_PER_DAY(HPD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  int unsigned t = 0;
  int unsigned alm = 0;
  bit armed = 1'b0, prev_armed = 1'b0;
  bit ms = 1'b0, mm = 1'b0, mh = 1'b0, md = 1'b0, mhit = 1'b0, merr = 1'b0;
  bit ld_ok, al_ok;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t = 0; alm = 0; armed = 0;
      ms = 0; mm = 0; mh = 0; md = 0; mhit = 0; merr = 0;
    end else begin
      al_ok = (int'(bus.set_hours) < HPD) && (int'(bus.set_minutes) < 60);
      ld_ok = al_ok && (int'(bus.set_seconds) < 60);
      prev_armed = armed;
      ms = 0; mm = 0; mh = 0; md = 0; mhit = 0;
      merr = (bus.set_stb && !ld_ok) || (bus.alarm_stb && !al_ok);
      if (bus.set_stb && ld_ok) begin
        t = ((int'(bus.set_hours) * 60 + int'(bus.set_minutes)) * 60 + int'(bus.set_seconds)) * TPS;
      end else if (bus.run) begin
        t = (t + 1) % DAYT;
        ms = (t % TPS) == 0;
        mm = (t % (60 * TPS)) == 0;
        mh = (t % (3600 * TPS)) == 0;
        md = (t == 0);
        mhit = mm && prev_armed && ((t / (60 * TPS)) == alm);
      end
      if (bus.alarm_stb && al_ok) alm = int'(bus.set_hours) * 60 + int'(bus.set_minutes);
      if (bus.alarm_clr) armed = 0;
      else if (bus.alarm_stb && al_ok) armed = 1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("sub",     32'(bus.sub),     t % TPS);
      check("seconds", 32'(bus.seconds), (t / TPS) % 60);
      check("minutes", 32'(bus.minutes), (t / (60 * TPS)) % 60);
      check("hours",   32'(bus.hours),   t / (3600 * TPS));
      check("s_tick",  32'(bus.s_tick),  32'(ms));
      check("m_tick",  32'(bus.m_tick),  32'(mm));
      check("h_tick",  32'(bus.h_tick),  32'(mh));
      check("d_tick",  32'(bus.d_tick),  32'(md));
      check("armed",   32'(bus.alarm_armed), 32'(armed));
      check("hit",     32'(bus.alarm_hit),   32'(mhit));
      check("set_err", 32'(bus.set_err),     32'(merr));
    end
  end

  task automatic set_time(input int h, input int m, input int s);
    @(negedge clk);
    bus.set_hours = h[4:0]; bus.set_minutes = m[5:0]; bus.set_seconds = s[5:0];
    bus.set_stb = 1'b1;
    @(negedge clk);
    bus.set_stb = 1'b0;
  endtask

  task automatic set_alarm(input int h, input int m, input bit clr);
    @(negedge clk);
    bus.set_hours = h[4:0]; bus.set_minutes = m[5:0]; bus.set_seconds = 6'd0;
    bus.alarm_stb = 1'b1; bus.alarm_clr = clr;
    @(negedge clk);
    bus.alarm_stb = 1'b0; bus.alarm_clr = 1'b0;
  endtask

  initial begin
    bus.run = 1'b0; bus.set_stb = 1'b0; bus.alarm_stb = 1'b0; bus.alarm_clr = 1'b0;
    bus.set_hours = 5'd0; bus.set_minutes = 6'd0; bus.set_seconds = 6'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0; chk_en = 1'b1; bus.run = 1'b1;

    // Asynchronous reset mid-count
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_sub", 32'(bus.sub), 32'd0);
    check("rst_sec", 32'(bus.seconds), 32'd0);
    check("rst_stk", 32'(bus.s_tick), 32'd0);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("rel_stick", 32'(bus.s_tick), 32'd1);
    check("rel_sec", 32'(bus.seconds), 32'd1);

    // Day rollover from 23:59:59
    set_time(23, 59, 59);
    repeat (4) @(posedge clk);
    #1 check("day_hours", 32'(bus.hours), 32'd0);
    check("day_min", 32'(bus.minutes), 32'd0);
    check("day_dtick", 32'(bus.d_tick), 32'd1);
    check("day_htick", 32'(bus.h_tick), 32'd1);
    @(posedge clk);
    #1 check("day_dtick_off", 32'(bus.d_tick), 32'd0);

    // Invalid loads while running
    set_time(24, 0, 0);
    check("err_h", 32'(bus.set_err), 32'd1);
    set_time(12, 60, 0);
    check("err_m", 32'(bus.set_err), 32'd1);
    set_time(12, 0, 60);
    check("err_s", 32'(bus.set_err), 32'd1);
    check("err_hours", 32'(bus.hours), 32'd0);

    // Alarm hit, direct load to alarm time, cleared alarm
    set_alarm(7, 30, 1'b0);
    check("alm_armed", 32'(bus.alarm_armed), 32'd1);
    set_time(7, 29, 59);
    repeat (4) @(posedge clk);
    #1 check("alm_hit", 32'(bus.alarm_hit), 32'd1);
    check("alm_mtick", 32'(bus.m_tick), 32'd1);
    check("alm_min", 32'(bus.minutes), 32'd30);
    set_time(7, 30, 0);
    check("alm_load_nohit", 32'(bus.alarm_hit), 32'd0);
    @(negedge clk); bus.alarm_clr = 1'b1;
    @(negedge clk); bus.alarm_clr = 1'b0;
    check("alm_cleared", 32'(bus.alarm_armed), 32'd0);
    set_time(7, 29, 59);
    repeat (4) @(posedge clk);
    #1 check("clr_mtick", 32'(bus.m_tick), 32'd1);
    check("clr_nohit", 32'(bus.alarm_hit), 32'd0);

    // Pause with sub==2, then resume
    set_time(3, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); bus.run = 1'b0;
    check("pause_sub", 32'(bus.sub), 32'd2);
    repeat (10) @(negedge clk);
    check("pause_hold", 32'(bus.sub), 32'd2);
    bus.run = 1'b1;
    @(posedge clk);
    #1 check("resume_sub3", 32'(bus.sub), 32'd3);
    check("resume_nostk", 32'(bus.s_tick), 32'd0);
    @(posedge clk);
    #1 check("resume_stk", 32'(bus.s_tick), 32'd1);
    check("resume_sec", 32'(bus.seconds), 32'd1);
    @(negedge clk); bus.run = 1'b0;
    set_time(10, 20, 30);
    check("pset_hours", 32'(bus.hours), 32'd10);
    check("pset_sec", 32'(bus.seconds), 32'd30);
    repeat (3) @(negedge clk);
    bus.run = 1'b1;

    // Load at the edge that would roll seconds over
    set_time(1, 2, 59);
    repeat (3) @(posedge clk);
    set_time(5, 6, 7);
    check("sim_min", 32'(bus.minutes), 32'd6);
    check("sim_sec", 32'(bus.seconds), 32'd7);
    check("sim_nostk", 32'(bus.s_tick), 32'd0);

    // Alarm arm and clear on the same edge
    set_alarm(8, 0, 1'b0);
    set_alarm(9, 15, 1'b1);
    check("stbclr_armed", 32'(bus.alarm_armed), 32'd0);

    // Set invalid (seconds) with a valid alarm on the same edge
    @(negedge clk);
    bus.set_hours = 5'd6; bus.set_minutes = 6'd45; bus.set_seconds = 6'd60;
    bus.set_stb = 1'b1; bus.alarm_stb = 1'b1;
    @(negedge clk);
    bus.set_stb = 1'b0; bus.alarm_stb = 1'b0;
    check("mix_err", 32'(bus.set_err), 32'd1);
    check("mix_armed", 32'(bus.alarm_armed), 32'd1);

    // Free run across another day boundary
    set_time(23, 59, 58);
    repeat (12) @(negedge clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
